// File: rtl/mm_pkg.sv
// Shared types and helpers for the systolic matrix multiplier.
// Holds the controller state encoding and the product extension helper.
package mm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        OUTPUT
    } state_t;

    // Extend a w-bit product to 64 bits, sign-filling when sgn is set.
    function automatic logic [63:0] ext_prod(
        input logic [63:0] p,
        input int unsigned w,
        input logic        sgn
    );
        logic [63:0] r;
        r = p;
        for (int unsigned i = 0; i < 64; i++) begin
            if (i >= w) r[i] = sgn & p[w-1];
        end
        return r;
    endfunction

endpackage

// File: rtl/systolic_mm_array_if.sv
// Operand, control and result bundle of the systolic multiplier.
// The driver side uses master, the array itself uses slave.
interface systolic_mm_array_if #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 20,
    parameter int K_WIDTH    = 8
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic                    START;
    logic [K_WIDTH-1:0]      K_LEN;
    logic                    IN_VALID;
    logic                    IN_READY;
    logic [N*DATA_WIDTH-1:0] A_COL;
    logic [N*DATA_WIDTH-1:0] B_ROW;
    logic                    OUT_VALID;
    logic                    OUT_READY;
    logic [N*ACC_WIDTH-1:0]  OUT_ROW;
    logic [IW-1:0]           OUT_IDX;
    logic                    BUSY;
    logic                    DONE;

    modport master (
        output START, K_LEN, IN_VALID, A_COL, B_ROW, OUT_READY,
        input  IN_READY, OUT_VALID, OUT_ROW, OUT_IDX, BUSY, DONE
    );

    modport slave (
        input  START, K_LEN, IN_VALID, A_COL, B_ROW, OUT_READY,
        output IN_READY, OUT_VALID, OUT_ROW, OUT_IDX, BUSY, DONE
    );

endinterface

// File: rtl/mm_pe.sv
// One processing element: multiply-accumulate plus operand forwarding.
// a moves right, b moves down, one register each per enabled cycle.
module mm_pe
    import mm_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 20,
    parameter int SIGNED     = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  clr_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [DATA_WIDTH-1:0] a_o,
    output logic [DATA_WIDTH-1:0] b_o,
    output logic [ACC_WIDTH-1:0]  acc_o
);
    localparam int PW = 2 * DATA_WIDTH;

    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic [ACC_WIDTH-1:0]  acc_q;
    logic [PW-1:0]         prod;
    logic [ACC_WIDTH-1:0]  prod_x;

    // Full-width product, then extend or truncate to the accumulator.
    always_comb begin
        if (SIGNED != 0) begin
            prod = $signed(PW'($signed(a_i))) * $signed(PW'($signed(b_i)));
        end else begin
            prod = PW'(a_i) * PW'(b_i);
        end
        prod_x = ACC_WIDTH'(ext_prod(64'(prod), PW, SIGNED != 0));
    end

    // Operand pipeline and wrapping accumulator, cleared on job start.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else if (en_i) begin
            a_q   <= a_i;
            b_q   <= b_i;
            acc_q <= acc_q + prod_x;
        end
    end

    assign a_o   = a_q;
    assign b_o   = b_q;
    assign acc_o = acc_q;

endmodule

// File: rtl/systolic_mm_array.sv
// Output-stationary N x N systolic multiplier C = A * B, K set per job.
// Holds the controller, the input skew chains and the PE grid.
module systolic_mm_array
    import mm_pkg::*;
#(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 20,
    parameter int K_WIDTH    = 8,
    parameter int SIGNED     = 0
) (
    input logic CLK,
    input logic RESET,
    systolic_mm_array_if.slave bus
);
    localparam int IW  = (N > 1) ? $clog2(N) : 1;
    localparam int DCW = $clog2(2 * N) + 1;
    localparam int DW  = DATA_WIDTH;
    localparam int AW  = ACC_WIDTH;

    state_t             state_q, state_d;
    logic [K_WIDTH-1:0] klen_q, klen_d;
    logic [K_WIDTH-1:0] kcnt_q, kcnt_d;
    logic [DCW-1:0]     dcnt_q, dcnt_d;
    logic [IW-1:0]      row_q, row_d;
    logic               done_q, done_d;

    logic            fire_in;
    logic            fire_out;
    logic            en;
    logic            clr;
    logic [N*DW-1:0] a_feed;
    logic [N*DW-1:0] b_feed;
    logic [N*AW-1:0] out_row;

    logic [DW-1:0] a_sk [N];
    logic [DW-1:0] b_sk [N];
    logic [DW-1:0] a_in [N][N];
    logic [DW-1:0] b_in [N][N];
    logic [DW-1:0] a_w  [N][N];
    logic [DW-1:0] b_w  [N][N];
    logic [AW-1:0] acc_w[N][N];

    assign fire_in  = (state_q == LOAD) && bus.IN_VALID;
    assign fire_out = (state_q == OUTPUT) && bus.OUT_READY;
    assign en       = fire_in || (state_q == DRAIN);
    assign clr      = (state_q == IDLE) && bus.START;
    assign a_feed   = (state_q == LOAD) ? bus.A_COL : '0;
    assign b_feed   = (state_q == LOAD) ? bus.B_ROW : '0;

    // Next-state logic for the job sequencer and its counters.
    always_comb begin
        state_d = state_q;
        klen_d  = klen_q;
        kcnt_d  = kcnt_q;
        dcnt_d  = dcnt_q;
        row_d   = row_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.START) begin
                    klen_d = bus.K_LEN;
                    kcnt_d = '0;
                    dcnt_d = '0;
                    row_d  = '0;
                    if (bus.K_LEN == '0) begin
                        state_d = (N == 1) ? OUTPUT : DRAIN;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (fire_in) begin
                    kcnt_d = kcnt_q + K_WIDTH'(1);
                    if (kcnt_q == klen_q - K_WIDTH'(1)) begin
                        state_d = (N == 1) ? OUTPUT : DRAIN;
                    end
                end
            end
            DRAIN: begin
                dcnt_d = dcnt_q + DCW'(1);
                if (dcnt_q == DCW'(2 * N - 3)) state_d = OUTPUT;
            end
            OUTPUT: begin
                if (fire_out) begin
                    if (row_q == IW'(N - 1)) begin
                        state_d = IDLE;
                        row_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        row_d = row_q + IW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer state register with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            klen_q  <= '0;
            kcnt_q  <= '0;
            dcnt_q  <= '0;
            row_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            klen_q  <= klen_d;
            kcnt_q  <= kcnt_d;
            dcnt_q  <= dcnt_d;
            row_q   <= row_d;
            done_q  <= done_d;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_skew
        if (i == 0) begin : g_direct
            assign a_sk[i] = a_feed[0 +: DW];
            assign b_sk[i] = b_feed[0 +: DW];
        end else begin : g_dly
            logic [DW-1:0] a_sh_q [i];
            logic [DW-1:0] b_sh_q [i];

            // Delay row/column i by i enabled cycles.
            always_ff @(posedge CLK) begin
                if (RESET || clr) begin
                    for (int m = 0; m < i; m++) begin
                        a_sh_q[m] <= '0;
                        b_sh_q[m] <= '0;
                    end
                end else if (en) begin
                    a_sh_q[0] <= a_feed[i*DW +: DW];
                    b_sh_q[0] <= b_feed[i*DW +: DW];
                    for (int m = 1; m < i; m++) begin
                        a_sh_q[m] <= a_sh_q[m-1];
                        b_sh_q[m] <= b_sh_q[m-1];
                    end
                end
            end

            assign a_sk[i] = a_sh_q[i-1];
            assign b_sk[i] = b_sh_q[i-1];
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            if (j == 0) begin : g_a0
                assign a_in[i][j] = a_sk[i];
            end else begin : g_an
                assign a_in[i][j] = a_w[i][j-1];
            end
            if (i == 0) begin : g_b0
                assign b_in[i][j] = b_sk[j];
            end else begin : g_bn
                assign b_in[i][j] = b_w[i-1][j];
            end

            mm_pe #(
                .DATA_WIDTH(DW),
                .ACC_WIDTH (AW),
                .SIGNED    (SIGNED)
            ) u_pe (
                .clk_i(CLK),
                .rst_i(RESET),
                .en_i (en),
                .clr_i(clr),
                .a_i  (a_in[i][j]),
                .b_i  (b_in[i][j]),
                .a_o  (a_w[i][j]),
                .b_o  (b_w[i][j]),
                .acc_o(acc_w[i][j])
            );
        end
    end

    // Select the accumulator row currently being presented.
    always_comb begin
        out_row = '0;
        for (int j = 0; j < N; j++) begin
            out_row[j*AW +: AW] = acc_w[row_q][j];
        end
    end

    assign bus.IN_READY  = (state_q == LOAD);
    assign bus.OUT_VALID = (state_q == OUTPUT);
    assign bus.OUT_ROW   = out_row;
    assign bus.OUT_IDX   = row_q;
    assign bus.BUSY      = (state_q != IDLE);
    assign bus.DONE      = done_q;

endmodule

// File: tb/tb_systolic_mm_array.sv
// Scoreboard bench: three lockstep arrays (20b unsigned, 16b unsigned,
// 20b signed) share stimulus; expected rows come from a reference model.
module tb_systolic_mm_array;
    localparam int N    = 2;
    localparam int DW   = 8;
    localparam int KW   = 8;
    localparam int KMAX = 8;
    localparam int AW0  = 20;
    localparam int AW1  = 16;
    localparam int AW2  = 20;
    localparam int RW   = N * 20;

    typedef struct {
        logic [RW-1:0] r0;
        logic [RW-1:0] r1;
        logic [RW-1:0] r2;
        int            idx;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [KW-1:0]   k_len = '0;
    logic            in_valid = 1'b0;
    logic [N*DW-1:0] a_col = '0;
    logic [N*DW-1:0] b_row = '0;
    logic            out_ready = 1'b1;

    logic [DW-1:0] am [N][KMAX];
    logic [DW-1:0] bm [KMAX][N];

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    logic done_exp = 1'b0;

    always #5 clk = ~clk;

    systolic_mm_array_if #(.N(N), .DATA_WIDTH(DW),
        .ACC_WIDTH(AW0), .K_WIDTH(KW)) if0 ();
    systolic_mm_array_if #(.N(N), .DATA_WIDTH(DW),
        .ACC_WIDTH(AW1), .K_WIDTH(KW)) if1 ();
    systolic_mm_array_if #(.N(N), .DATA_WIDTH(DW),
        .ACC_WIDTH(AW2), .K_WIDTH(KW)) if2 ();

    assign if0.START = start;
    assign if0.K_LEN = k_len;
    assign if0.IN_VALID = in_valid;
    assign if0.A_COL = a_col;
    assign if0.B_ROW = b_row;
    assign if0.OUT_READY = out_ready;
    assign if1.START = start;
    assign if1.K_LEN = k_len;
    assign if1.IN_VALID = in_valid;
    assign if1.A_COL = a_col;
    assign if1.B_ROW = b_row;
    assign if1.OUT_READY = out_ready;
    assign if2.START = start;
    assign if2.K_LEN = k_len;
    assign if2.IN_VALID = in_valid;
    assign if2.A_COL = a_col;
    assign if2.B_ROW = b_row;
    assign if2.OUT_READY = out_ready;

    systolic_mm_array #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW0),
        .K_WIDTH(KW), .SIGNED(0)) dut0 (
        .CLK(clk), .RESET(reset), .bus(if0));
    systolic_mm_array #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW1),
        .K_WIDTH(KW), .SIGNED(0)) dut1 (
        .CLK(clk), .RESET(reset), .bus(if1));
    systolic_mm_array #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW2),
        .K_WIDTH(KW), .SIGNED(1)) dut2 (
        .CLK(clk), .RESET(reset), .bus(if2));

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_elem(int i, int j, int k,
                                             int aw, bit sg);
        longint acc;
        longint x;
        longint y;
        acc = 0;
        for (int kk = 0; kk < k; kk++) begin
            x = sg ? longint'($signed(am[i][kk])) : longint'(am[i][kk]);
            y = sg ? longint'($signed(bm[kk][j])) : longint'(bm[kk][j]);
            acc += x * y;
        end
        return 64'(acc) & ((64'd1 << aw) - 64'd1);
    endfunction

    function automatic logic [RW-1:0] ref_row(int i, int k, int aw, bit sg);
        logic [RW-1:0] r;
        logic [63:0]   e;
        r = '0;
        for (int j = 0; j < N; j++) begin
            e = ref_elem(i, j, k, aw, sg);
            for (int b = 0; b < aw; b++) r[j*aw + b] = e[b];
        end
        return r;
    endfunction

    function automatic logic [N*DW-1:0] pack_a(int k);
        logic [N*DW-1:0] c;
        for (int i = 0; i < N; i++) c[i*DW +: DW] = am[i][k];
        return c;
    endfunction

    function automatic logic [N*DW-1:0] pack_b(int k);
        logic [N*DW-1:0] c;
        for (int j = 0; j < N; j++) c[j*DW +: DW] = bm[k][j];
        return c;
    endfunction

    task automatic push_exp(input int k);
        exp_t e;
        for (int i = 0; i < N; i++) begin
            e.r0  = ref_row(i, k, AW0, 1'b0);
            e.r1  = ref_row(i, k, AW1, 1'b0);
            e.r2  = ref_row(i, k, AW2, 1'b1);
            e.idx = i;
            sb.push_back(e);
        end
    endtask

    task automatic set_t1();
        am[0][0] = 8'd1; am[0][1] = 8'd2;
        am[1][0] = 8'd3; am[1][1] = 8'd4;
        bm[0][0] = 8'd5; bm[0][1] = 8'd6;
        bm[1][0] = 8'd7; bm[1][1] = 8'd8;
    endtask

    task automatic fill(input bit rnd, input logic [DW-1:0] v);
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < KMAX; k++) begin
                am[i][k] = rnd ? DW'($urandom) : v;
                bm[k][i] = rnd ? DW'($urandom) : v;
            end
        end
    endtask

    // Scoreboard pop on every accepted row, plus DONE pulse tracking.
    always @(negedge clk) begin
        exp_t e;
        chk("done_u20", 64'(if0.DONE), 64'(done_exp));
        chk("done_u16", 64'(if1.DONE), 64'(done_exp));
        chk("done_s20", 64'(if2.DONE), 64'(done_exp));
        if (if0.DONE === 1'b1) done_cnt++;
        done_exp = 1'b0;
        if (!reset && if0.OUT_VALID === 1'b1 && out_ready) begin
            if (sb.size() == 0) begin
                chk("extra_row", 64'(if0.OUT_VALID), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("row_u20", 64'(if0.OUT_ROW), 64'(e.r0));
                chk("row_u16", 64'(if1.OUT_ROW), 64'(e.r1));
                chk("row_s20", 64'(if2.OUT_ROW), 64'(e.r2));
                chk("idx", 64'(if0.OUT_IDX), 64'(e.idx));
                chk("valid_s20", 64'(if2.OUT_VALID), 64'd1);
                if (e.idx == N - 1) done_exp = 1'b1;
            end
        end
    end

    task automatic run_job(input int k, input int gap,
                           input bit stall, input bit hold);
        int cnt;
        int rdy;
        out_ready = !stall;
        push_exp(k);
        start = 1'b1;
        k_len = KW'(k);
        @(posedge clk); #1;
        start = 1'b0;
        for (int t = 0; t < k; t++) begin
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                a_col = N*DW'($urandom);
                chk("ready_gap", 64'(if0.IN_READY), 64'd1);
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            a_col = pack_a(t);
            b_row = pack_b(t);
            chk("ready_beat", 64'(if0.IN_READY), 64'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        a_col = N*DW'($urandom);
        b_row = N*DW'($urandom);
        cnt = 0;
        rdy = 0;
        if (hold) begin
            start = 1'b1;
            k_len = KW'(3);
        end
        while (if0.OUT_VALID !== 1'b1 && cnt < 100) begin
            if (if0.IN_READY === 1'b1) rdy++;
            @(posedge clk); #1;
            cnt++;
        end
        if (gap == 0) chk("latency", 64'(k + cnt), 64'(k + 2*N - 2));
        if (stall) begin
            for (int s = 0; s < 5; s++) begin
                chk("stall_valid", 64'(if0.OUT_VALID), 64'd1);
                chk("stall_idx", 64'(if0.OUT_IDX), 64'd0);
                chk("stall_u20", 64'(if0.OUT_ROW), 64'(sb[0].r0));
                chk("stall_s20", 64'(if2.OUT_ROW), 64'(sb[0].r2));
                @(posedge clk); #1;
            end
            out_ready = 1'b1;
        end
        cnt = 0;
        while (if0.BUSY !== 1'b0 && cnt < 100) begin
            if (if0.IN_READY === 1'b1) rdy++;
            @(posedge clk); #1;
            cnt++;
        end
        start = 1'b0;
        in_valid = 1'b0;
        chk("job_end", 64'(if0.BUSY), 64'd0);
        chk("no_ready", 64'(rdy), 64'd0);
        @(posedge clk); #1;
        chk("idle_busy", 64'(if0.BUSY), 64'd0);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(if0.BUSY), 64'd0);
        chk("rst_ready", 64'(if0.IN_READY), 64'd0);
        chk("rst_valid", 64'(if0.OUT_VALID), 64'd0);
        chk("rst_idx", 64'(if0.OUT_IDX), 64'd0);
        chk("rst_row0", 64'(if0.OUT_ROW), 64'd0);
        chk("rst_row1", 64'(if1.OUT_ROW), 64'd0);
        chk("rst_row2", 64'(if2.OUT_ROW), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        set_t1();
        run_job(2, 0, 1'b0, 1'b0);
        run_job(2, 3, 1'b0, 1'b0);
        run_job(2, 0, 1'b1, 1'b0);
        fill(1'b0, 8'hFF);
        run_job(2, 0, 1'b0, 1'b0);
        run_job(0, 0, 1'b0, 1'b1);
        fill(1'b1, 8'h00);
        run_job(5, 1, 1'b0, 1'b0);
        fill(1'b1, 8'h00);
        run_job(KMAX, 0, 1'b1, 1'b0);

        set_t1();
        start = 1'b1;
        k_len = KW'(2);
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1;
        a_col = pack_a(0);
        b_row = pack_b(0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_busy", 64'(if0.BUSY), 64'd0);
        chk("abort_ready", 64'(if0.IN_READY), 64'd0);
        chk("abort_valid", 64'(if0.OUT_VALID), 64'd0);
        chk("abort_row0", 64'(if0.OUT_ROW), 64'd0);
        chk("abort_row2", 64'(if2.OUT_ROW), 64'd0);
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            if (if0.OUT_VALID === 1'b1) seen++;
            @(posedge clk); #1;
        end
        chk("abort_quiet", 64'(seen), 64'd0);
        run_job(2, 0, 1'b0, 1'b0);

        chk("done_count", 64'(done_cnt), 64'd8);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
